// File: rtl/div_pkg.sv
// Shared definitions for the sequential HI/LO divider.
// Provides: FSM state encodings, default operand width, and 64-bit abs/negate
// helpers (callers truncate to their own width; two's-complement negation is width-agnostic).
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic [63:0] div_neg(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  // Conditional negate: returns the magnitude when neg is the operand's sign bit,
  // or applies the result sign when neg is a stored sign flag.
  function automatic logic [63:0] div_abs(input logic [63:0] x, input logic neg);
    return neg ? div_neg(x) : x;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle between the control FSM (master) and the divider (slave).
// master drives start/stop/is_signed/n/d; slave returns busy/done/hi/lo/divzero.
// done is a one-cycle pulse; there is no backpressure, the master must read hi/lo on or after done.
interface div_seq_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic             stop;
  logic             is_signed;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] d;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             divzero;

  modport master (
    output start, stop, is_signed, n, d,
    input  busy, done, hi, lo, divzero
  );

  modport slave (
    input  start, stop, is_signed, n, d,
    output busy, done, hi, lo, divzero
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
// Ports: r (partial remainder, always < d), bit_in (next dividend bit, MSB first), d (divisor),
//        r_next (updated remainder), q_bit (quotient bit for this position). Zero latency, no handshake.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);
  // The shifted remainder needs one extra bit: with r < d <= 2^WIDTH-1, 2r+1 can
  // exceed WIDTH bits when the divisor has its MSB set.
  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  assign partial = {r, bit_in};
  assign diff    = partial - {1'b0, d};
  assign q_bit   = (partial >= {1'b0, d});
  // partial < 2d, so a successful subtraction always fits back into WIDTH bits.
  assign r_next  = q_bit ? WIDTH'(diff) : partial[WIDTH-1:0];
endmodule

// File: rtl/div_seq.sv
// Multicycle restoring divider: quotient on lo, remainder on hi, divide-by-zero flag.
// Latency: done pulses WIDTH+1 cycles after the accepting edge (1 cycle for d==0).
// No backpressure: start is only taken in IDLE, ignored while busy; stop aborts without done.
// Ports: clk, rst (sync, active-high), bus (div_seq_if.slave).
// Build option DIV_SIGNED_EN: honour is_signed (two's-complement DIV); otherwise all ops unsigned.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  div_seq_if.slave    bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] nn;      // dividend magnitude, shifted left so the next bit is always the MSB
  logic [WIDTH-1:0] dd;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dz;
  logic             done_r;
  logic             divzero_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic             accept;
  logic [WIDTH-1:0] n_mag;
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH-1:0] lo_fix;
  logic [WIDTH-1:0] hi_fix;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;

  // stop has priority over start, so an op is never accepted on an aborting edge.
  assign accept = (state == ST_IDLE) && bus.start && !bus.stop;

`ifdef DIV_SIGNED_EN
  logic n_neg;
  logic d_neg;
  logic sign_q;
  logic sign_r;

  assign n_neg  = bus.is_signed & bus.n[WIDTH-1];
  assign d_neg  = bus.is_signed & bus.d[WIDTH-1];
  // |MIN| wraps to MIN, which is the correct magnitude when read as unsigned.
  assign n_mag  = WIDTH'(div_abs(64'(bus.n), n_neg));
  assign d_mag  = WIDTH'(div_abs(64'(bus.d), d_neg));
  assign lo_fix = WIDTH'(div_abs(64'(q), sign_q));
  assign hi_fix = WIDTH'(div_abs(64'(r), sign_r));

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (accept) begin
      sign_q <= n_neg ^ d_neg;
      sign_r <= n_neg;      // remainder follows the dividend's sign
    end
  end
`else
  // is_signed has no effect in the unsigned-only build.
  logic unused_is_signed;
  assign unused_is_signed = bus.is_signed;
  assign n_mag  = bus.n;
  assign d_mag  = bus.d;
  assign lo_fix = q;
  assign hi_fix = r;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .bit_in (nn[WIDTH-1]),
    .d      (dd),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      nn        <= '0;
      dd        <= '0;
      q         <= '0;
      r         <= '0;
      dz        <= 1'b0;
      done_r    <= 1'b0;
      divzero_r <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      done_r <= 1'b0;
      if (bus.stop) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              nn        <= n_mag;
              dd        <= d_mag;
              q         <= '0;
              r         <= '0;
              dz        <= (bus.d == '0);
              divzero_r <= 1'b0;
              cnt       <= CNT_W'(WIDTH - 1);
              state     <= (bus.d == '0) ? ST_FIX : ST_ITER;
            end
          end
          ST_ITER: begin
            r     <= r_next;
            q     <= {q[WIDTH-2:0], q_bit};
            nn    <= {nn[WIDTH-2:0], 1'b0};
            cnt   <= cnt - 1'b1;
            if (cnt == '0) state <= ST_FIX;
          end
          ST_FIX: begin
            if (dz) begin
              hi_r      <= '0;
              lo_r      <= '0;
              divzero_r <= 1'b1;
            end else begin
              hi_r <= hi_fix;
              lo_r <= lo_fix;
            end
            done_r <= 1'b1;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = done_r;
  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;
  assign bus.divzero = divzero_r;
endmodule
